// File: rtl/signed_adder_pkg.sv
// Shared constant helpers for the signed adder tree: tree depth, full
// result width, per-level node counts and saturation bounds.
package signed_adder_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int full_width(input int iwidth, input int nch);
        return iwidth + clog2(nch);
    endfunction

    // Operands left after 'lvl' pairwise levels; an odd one rides along.
    function automatic int node_count(input int nch, input int lvl);
        int c;
        c = nch;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    function automatic longint sat_hi(input int owidth);
        return (longint'(1) <<< (owidth - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int owidth);
        return -(longint'(1) <<< (owidth - 1));
    endfunction

endpackage

// File: rtl/signed_adder_reg.sv
// One tree node: sign-extend two W-bit operands, add exactly into W+1 bits,
// and register the result when the incoming valid bit is set.
module signed_adder_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= {a[W-1], a} + {b[W-1], b};
        end
    end

endmodule

// File: rtl/signed_adder_tree.sv
// Pipelined signed adder tree: clog2(NCH) registered adder levels followed
// by one output register that sign-extends, saturates or wraps the sum.
module signed_adder_tree
    import signed_adder_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int IWIDTH = 4,
    parameter int OWIDTH = IWIDTH + clog2(NCH),
    parameter int SAT    = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    input  logic [NCH*IWIDTH-1:0]    i_data,
    output logic                     o_valid,
    output logic signed [OWIDTH-1:0] o_sum,
    output logic                     o_ovf
);

    localparam int LEVELS = clog2(NCH);
    localparam int FW     = full_width(IWIDTH, NCH);
    localparam int LAT    = LEVELS + 1;

    // i_valid qualifies i_data for exactly one cycle and there is no ready:
    // every valid set is accepted, and o_valid pulses once per set LAT later.
    logic [LAT-1:0] vld;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-2:0], i_valid};
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int W    = IWIDTH + l;
        localparam int NIN  = node_count(NCH, l);
        localparam int NOUT = node_count(NCH, l + 1);

        logic [NIN*W-1:0]      din;
        logic [NOUT*(W+1)-1:0] dout;
        logic                  en;

        if (l == 0) begin : g_src
            assign din = i_data;
            assign en  = i_valid;
        end else begin : g_src
            assign din = g_lvl[l-1].dout;
            assign en  = vld[l-1];
        end

        for (genvar j = 0; j < NOUT; j++) begin : g_node
            logic [W-1:0] b;

            // An unpaired last operand is added to zero, i.e. just widened.
            if (2 * j + 1 < NIN) begin : g_pair
                assign b = din[(2*j+1)*W +: W];
            end else begin : g_single
                assign b = '0;
            end

            signed_adder_reg #(.W(W)) u_node (
                .clk     (i_clk),
                .reset_n (i_reset_n),
                .en      (en),
                .a       (din[2*j*W +: W]),
                .b       (b),
                .sum     (dout[j*(W+1) +: W+1])
            );
        end
    end

    logic [FW-1:0]     tree_sum;
    logic [OWIDTH-1:0] conv_sum;
    logic              conv_ovf;

    assign tree_sum = g_lvl[LEVELS-1].dout;

    if (OWIDTH >= FW) begin : g_ext
        assign conv_sum = OWIDTH'($signed(tree_sum));
        assign conv_ovf = 1'b0;
    end else if (SAT != 0) begin : g_sat
        localparam logic signed [FW-1:0] HI = FW'(sat_hi(OWIDTH));
        localparam logic signed [FW-1:0] LO = FW'(sat_lo(OWIDTH));

        always_comb begin
            conv_sum = tree_sum[OWIDTH-1:0];
            conv_ovf = 1'b0;
            if ($signed(tree_sum) > HI) begin
                conv_sum = HI[OWIDTH-1:0];
                conv_ovf = 1'b1;
            end else if ($signed(tree_sum) < LO) begin
                conv_sum = LO[OWIDTH-1:0];
                conv_ovf = 1'b1;
            end
        end
    end else begin : g_wrap
        // Overflow whenever the dropped bits are not copies of the new MSB.
        assign conv_sum = tree_sum[OWIDTH-1:0];
        assign conv_ovf = tree_sum[FW-1:OWIDTH] != {(FW-OWIDTH){tree_sum[OWIDTH-1]}};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_sum <= '0;
            o_ovf <= 1'b0;
        end else if (vld[LEVELS-1]) begin
            o_sum <= conv_sum;
            o_ovf <= conv_ovf;
        end
    end

    assign o_valid = vld[LAT-1];

endmodule

// File: doc/signed_adder_tree.md
SIGNED_ADDER_TREE -- requirements
Module: signed_adder_tree

Interface
REQ-001 SHALL have parameter NCH, default 4: number of signed input channels, legal range 2..64.
REQ-002 SHALL have parameter IWIDTH, default 4: per-channel input width in bits.
REQ-003 SHALL have parameter OWIDTH, default IWIDTH+clog2(NCH): output width in bits.
REQ-004 SHALL have parameter SAT, default 1: 1 saturates, 0 wraps, applied when OWIDTH < FW.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port i_valid, input, 1: i_data is a valid operand set this cycle.
REQ-008 SHALL have port i_data, input, NCH*IWIDTH: packed signed channels; channel k occupies bits [k*IWIDTH +: IWIDTH].
REQ-009 SHALL have port o_valid, output, 1: o_sum holds a new result this cycle.
REQ-010 SHALL have port o_sum, output, OWIDTH, signed: sum of one operand set.
REQ-011 SHALL have port o_ovf, output, 1: the result in o_sum was saturated (SAT=1) or wrapped (SAT=0).

Function
REQ-012 SHALL define full width FW = IWIDTH + clog2(NCH); all internal sums are exact and sign-extended.
REQ-013 SHALL compute the sum with a binary tree of clog2(NCH) registered adder levels.
REQ-014 SHALL widen each level's node width by 1 bit over its operands.
REQ-015 SHALL, at a level with an odd operand count, pass the unpaired operand sign-extended and registered, equivalent to adding zero.
REQ-016 SHALL follow the tree with one output register that applies width conversion.
REQ-017 SHALL have total latency LAT = clog2(NCH)+1 cycles: i_valid at cycle t gives o_valid at cycle t+LAT.
REQ-018 SHALL accept one operand set per cycle with no backpressure; back-to-back valids give back-to-back results in order.
REQ-019 SHALL carry valid through a LAT-deep shift register.
REQ-020 SHALL update each data stage register only when the valid bit entering that stage is 1.
REQ-021 SHALL hold o_sum and o_ovf at the last result while o_valid=0.
REQ-022 SHALL, when OWIDTH >= FW, sign-extend the result to OWIDTH; o_ovf SHALL be 0.
REQ-023 SHALL, when OWIDTH < FW and SAT=1, clamp to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1] and set o_ovf=1 whenever clamping occurred.
REQ-024 SHALL, when OWIDTH < FW and SAT=0, output the low OWIDTH bits and set o_ovf=1 if the discarded bits are not a sign extension.
REQ-025 SHALL ignore i_data in cycles where i_valid=0; such cycles produce no result.

Reset
REQ-026 SHALL, while i_reset_n=0 at a rising edge, clear all valid bits and drive o_valid=0, o_sum=0, o_ovf=0 from the following cycle.
REQ-027 SHALL clear all pipeline data registers to 0 at the same time.
REQ-028 SHALL discard operand sets in flight when reset is asserted mid-operation; no o_valid SHALL appear for them.
REQ-029 SHALL produce the first result exactly LAT cycles after the first valid input accepted following reset release.

Structure
REQ-030 SHALL place clog2, FW derivation and the saturation bound helpers in package signed_adder_pkg.
REQ-031 SHALL implement one tree node (sign-extend, add, register with enable) as sub-module signed_adder_reg, instantiated per node with a generate loop.
REQ-032 SHALL keep the output width/saturation stage in the top-level module.

Verification
REQ-033 SHALL test NCH=4, IWIDTH=4, OWIDTH=6: one valid cycle of all channels = -8 -> o_sum=-32, o_valid exactly 3 cycles later, o_ovf=0.
REQ-034 SHALL test NCH=4, IWIDTH=4, OWIDTH=5, SAT=1: all 7 -> o_sum=15, o_ovf=1; then all -8 -> o_sum=-16, o_ovf=1; then {1,2,3,4} -> 10, o_ovf=0.
REQ-035 SHALL test NCH=4, IWIDTH=4, OWIDTH=5, SAT=0: all 7 -> o_sum=-4 (28 wrapped), o_ovf=1.
REQ-036 SHALL test NCH=3, IWIDTH=4: {7,7,7} -> 21, {-8,-8,-8} -> -24, latency 3.
REQ-037 SHALL test 5 back-to-back valids {k,k,k,k} for k=-2..2 -> o_sum -8,-4,0,4,8 on consecutive cycles; a one-cycle i_valid gap gives a one-cycle o_valid gap with o_sum held.
REQ-038 SHALL test reset asserted one cycle after 2 valid inputs: no o_valid afterwards; o_sum=0 and o_ovf=0 until new input; first post-reset result at LAT.
